// File: rtl/peb_frame_sched.sv
// peb_frame_sched: frame/block sequencer and psum readout scheduler for one PEB.
// The main FSM counts blocks and frames and issues the frame-finish pulse that
// flips the PEB ping-pong psum banks. The readout FSM streams the finished bank
// to the pooling unit. A frame end that arrives while the previous bank is
// still being read is held as "pending" (with PEB_Stall raised) until the last
// word of that readout has been presented, so a bank is never overwritten early.
module peb_frame_sched #(
  parameter int LENPSUM = 16,
  parameter int ADDR_W  = $clog2(LENPSUM),
  parameter int BLK_W   = 8,
  parameter int FRM_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CFG_Start,
  input  logic [BLK_W-1:0]  CFG_NumBlk,
  input  logic [FRM_W-1:0]  CFG_NumFrm,
  input  logic              PEB_BlkDone,
  output logic              CTRLPEB_FrtBlk,
  output logic              CTRLPEB_FnhFrm,
  output logic              PEB_Stall,
  output logic              POOLPEB_EnRd,
  output logic [ADDR_W-1:0] POOLPEB_AddrRd,
  input  logic              POOL_Rdy,
  output logic              POOL_Vld,
  output logic              POOL_Lst,
  output logic              SCH_Busy,
  output logic              SCH_Done
);

  localparam logic [BLK_W-1:0]  BLK_ZERO  = BLK_W'(0);
  localparam logic [BLK_W-1:0]  BLK_ONE   = BLK_W'(1);
  localparam logic [FRM_W-1:0]  FRM_ZERO  = FRM_W'(0);
  localparam logic [FRM_W-1:0]  FRM_ONE   = FRM_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LENPSUM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mainState_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ACT  = 1'b1
  } rdState_t;

  mainState_t        state, stateNxt;
  rdState_t          rdState, rdStateNxt;
  logic [BLK_W-1:0]  numBlk, numBlkNxt;
  logic [FRM_W-1:0]  numFrm, numFrmNxt;
  logic [BLK_W-1:0]  blkCnt, blkCntNxt;
  logic [FRM_W-1:0]  frmCnt, frmCntNxt;
  logic              pending, pendingNxt;
  logic [ADDR_W-1:0] rdAddr, rdAddrNxt;
  logic              doneNxt;

  logic startAcc;
  logic rdBusy;
  logic rdFinish;
  logic frameEnd;
  logic lastFrm;
  logic launch;
  logic enRd;

  // Read enable is gated live by POOL_Rdy so a back-pressured pool never gets a new word.
  assign POOLPEB_EnRd   = enRd;
  assign POOLPEB_AddrRd = rdAddr;

  // Next-state logic for the block/frame sequencer and the readout engine.
  always_comb begin
    stateNxt   = state;
    rdStateNxt = rdState;
    numBlkNxt  = numBlk;
    numFrmNxt  = numFrm;
    blkCntNxt  = blkCnt;
    frmCntNxt  = frmCnt;
    pendingNxt = pending;
    rdAddrNxt  = rdAddr;
    doneNxt    = 1'b0;

    startAcc = (state == IDLE) && CFG_Start;
    rdBusy   = (rdState == RD_ACT);
    // The cycle carrying the final word of a readout: the bank is free after it.
    rdFinish = POOL_Vld && POOL_Lst;
    // While pending, upstream is stalled and further block completions are ignored.
    frameEnd = (state == RUN) && !pending && PEB_BlkDone && (blkCnt == (numBlk - BLK_ONE));
    lastFrm  = (frmCnt == (numFrm - FRM_ONE));
    // A frame-finish pulse is issued either right away or once the in-flight readout drains.
    launch   = (frameEnd && !rdBusy) || (pending && rdFinish);
    enRd     = rdBusy && POOL_Rdy;

    case (state)
      IDLE: begin
        if (startAcc) begin
          stateNxt   = RUN;
          numBlkNxt  = (CFG_NumBlk == BLK_ZERO) ? BLK_ONE : CFG_NumBlk;
          numFrmNxt  = (CFG_NumFrm == FRM_ZERO) ? FRM_ONE : CFG_NumFrm;
          blkCntNxt  = BLK_ZERO;
          frmCntNxt  = FRM_ZERO;
          pendingNxt = 1'b0;
        end else begin
          stateNxt = IDLE;
        end
      end
      RUN: begin
        if (launch) begin
          blkCntNxt  = BLK_ZERO;
          frmCntNxt  = frmCnt + FRM_ONE;
          pendingNxt = 1'b0;
          if (lastFrm) begin
            stateNxt = DRAIN;
          end else begin
            stateNxt = RUN;
          end
        end else if (frameEnd) begin
          pendingNxt = 1'b1;
          blkCntNxt  = BLK_ZERO;
        end else if (PEB_BlkDone && !pending) begin
          blkCntNxt = blkCnt + BLK_ONE;
        end else begin
          blkCntNxt = blkCnt;
        end
      end
      DRAIN: begin
        if (rdFinish) begin
          stateNxt = IDLE;
          doneNxt  = 1'b1;
        end else begin
          stateNxt = DRAIN;
        end
      end
      default: begin
        stateNxt   = IDLE;
        pendingNxt = 1'b0;
        blkCntNxt  = BLK_ZERO;
        frmCntNxt  = FRM_ZERO;
      end
    endcase

    if (launch) begin
      rdStateNxt = RD_ACT;
      rdAddrNxt  = ADDR_ZERO;
    end else begin
      case (rdState)
        RD_ACT: begin
          if (enRd) begin
            if (rdAddr == ADDR_LAST) begin
              rdStateNxt = RD_IDLE;
              rdAddrNxt  = ADDR_ZERO;
            end else begin
              rdAddrNxt = rdAddr + ADDR_ONE;
            end
          end else begin
            rdAddrNxt = rdAddr;
          end
        end
        RD_IDLE: begin
          rdStateNxt = RD_IDLE;
        end
        default: begin
          rdStateNxt = RD_IDLE;
          rdAddrNxt  = ADDR_ZERO;
        end
      endcase
    end
  end

  // State registers plus registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rdState        <= RD_IDLE;
      numBlk         <= BLK_ZERO;
      numFrm         <= FRM_ZERO;
      blkCnt         <= BLK_ZERO;
      frmCnt         <= FRM_ZERO;
      pending        <= 1'b0;
      rdAddr         <= ADDR_ZERO;
      CTRLPEB_FrtBlk <= 1'b0;
      CTRLPEB_FnhFrm <= 1'b0;
      PEB_Stall      <= 1'b0;
      POOL_Vld       <= 1'b0;
      POOL_Lst       <= 1'b0;
      SCH_Busy       <= 1'b0;
      SCH_Done       <= 1'b0;
    end else begin
      state          <= stateNxt;
      rdState        <= rdStateNxt;
      numBlk         <= numBlkNxt;
      numFrm         <= numFrmNxt;
      blkCnt         <= blkCntNxt;
      frmCnt         <= frmCntNxt;
      pending        <= pendingNxt;
      rdAddr         <= rdAddrNxt;
      CTRLPEB_FrtBlk <= (stateNxt == RUN) && (blkCntNxt == BLK_ZERO) && !pendingNxt;
      CTRLPEB_FnhFrm <= launch;
      PEB_Stall      <= pendingNxt;
      // SRAM read latency is one cycle, so valid/last trail the read enable by one.
      POOL_Vld       <= enRd;
      POOL_Lst       <= enRd && (rdAddr == ADDR_LAST);
      SCH_Busy       <= (stateNxt != IDLE) || (rdStateNxt != RD_IDLE) || pendingNxt;
      SCH_Done       <= doneNxt;
    end
  end

endmodule

// File: tb/tb_peb_frame_sched.sv
// Self-checking bench for peb_frame_sched. Each scenario is planned up front:
// the stimulus (start, block-done and pool-ready per cycle) and the expected
// output trace are derived from frame-level timing rules, then replayed and
// compared cycle by cycle.
module tb_peb_frame_sched;

  localparam int LEN  = 16;
  localparam int MAXC = 700;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       CFG_Start;
  logic [7:0] CFG_NumBlk;
  logic [7:0] CFG_NumFrm;
  logic       PEB_BlkDone;
  logic       CTRLPEB_FrtBlk;
  logic       CTRLPEB_FnhFrm;
  logic       PEB_Stall;
  logic       POOLPEB_EnRd;
  logic [3:0] POOLPEB_AddrRd;
  logic       POOL_Rdy;
  logic       POOL_Vld;
  logic       POOL_Lst;
  logic       SCH_Busy;
  logic       SCH_Done;

  peb_frame_sched #(.LENPSUM(LEN), .ADDR_W(4), .BLK_W(8), .FRM_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .CFG_Start(CFG_Start), .CFG_NumBlk(CFG_NumBlk), .CFG_NumFrm(CFG_NumFrm),
    .PEB_BlkDone(PEB_BlkDone),
    .CTRLPEB_FrtBlk(CTRLPEB_FrtBlk), .CTRLPEB_FnhFrm(CTRLPEB_FnhFrm),
    .PEB_Stall(PEB_Stall),
    .POOLPEB_EnRd(POOLPEB_EnRd), .POOLPEB_AddrRd(POOLPEB_AddrRd),
    .POOL_Rdy(POOL_Rdy), .POOL_Vld(POOL_Vld), .POOL_Lst(POOL_Lst),
    .SCH_Busy(SCH_Busy), .SCH_Done(SCH_Done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // planned stimulus
  bit stStart[MAXC];
  bit stBlk[MAXC];
  bit stRdy[MAXC];
  // expected trace
  bit exFrt[MAXC];
  bit exFnh[MAXC];
  bit exStall[MAXC];
  bit exEnRd[MAXC];
  bit exVld[MAXC];
  bit exLst[MAXC];
  bit exBusy[MAXC];
  bit exDone[MAXC];
  int exAddr[MAXC];
  int runLen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plan one layer. gapMode 0 = random gaps 1..12, otherwise fixed gap.
  // rdyMode 0 = always ready, 1 = ready on even cycles, 2 = random (3/4).
  task automatic buildScenario(input int nb, input int nf, input int gapMode, input int rdyMode);
    int s, nbE, nfE, d, prevE, freeFrom, startF, fnh, gap, c, i;
    for (int k = 0; k < MAXC; k++) begin
      stStart[k] = 1'b0; stBlk[k] = 1'b0;
      exFrt[k] = 1'b0; exFnh[k] = 1'b0; exStall[k] = 1'b0; exEnRd[k] = 1'b0;
      exVld[k] = 1'b0; exLst[k] = 1'b0; exBusy[k] = 1'b0; exDone[k] = 1'b0;
      exAddr[k] = 0;
      if (rdyMode == 0)      stRdy[k] = 1'b1;
      else if (rdyMode == 1) stRdy[k] = ((k % 2) == 0);
      else                   stRdy[k] = ($urandom_range(0, 3) != 0);
    end
    CFG_NumBlk = nb[7:0];
    CFG_NumFrm = nf[7:0];
    nbE = (nb == 0) ? 1 : nb;
    nfE = (nf == 0) ? 1 : nf;
    s = 3;
    stBlk[1] = 1'b1;        // block-done while idle: ignored
    stStart[s] = 1'b1;
    stStart[s + 2] = 1'b1;  // second start while running: ignored
    d = s; prevE = -10; freeFrom = s + 1; startF = s + 1; fnh = 0;
    for (int f = 0; f < nfE; f++) begin
      for (int b = 0; b < nbE; b++) begin
        gap = (gapMode == 0) ? $urandom_range(1, 12) : gapMode;
        d = d + gap;
        if (d < freeFrom) d = freeFrom;
        stBlk[d] = 1'b1;
        if (b == 0) for (int k = startF; k <= d; k++) exFrt[k] = 1'b1;
      end
      // frame end at cycle d; bank is busy while the previous readout still issues reads
      if (d <= prevE) begin
        fnh = prevE + 2;
        for (int k = d + 1; k < fnh; k++) exStall[k] = 1'b1;
      end else begin
        fnh = d + 1;
      end
      freeFrom = fnh;
      startF = fnh;
      exFnh[fnh] = 1'b1;
      c = fnh; i = 0;
      while (i < LEN && c < MAXC - 10) begin
        if (stRdy[c]) begin
          exEnRd[c] = 1'b1; exAddr[c] = i; exVld[c + 1] = 1'b1;
          prevE = c; i++;
        end
        c++;
      end
      exLst[prevE + 1] = 1'b1;
    end
    stBlk[fnh] = 1'b1;  // block-done in drain: ignored
    for (int k = s + 1; k <= prevE + 1; k++) exBusy[k] = 1'b1;
    exDone[prevE + 2] = 1'b1;
    stBlk[prevE + 4] = 1'b1;  // idle again: ignored
    runLen = prevE + 6;
  endtask

  task automatic runScenario(input string name);
    logic [7:0] obs, exp;
    for (int c = 0; c < runLen; c++) begin
      @(posedge clk); #1;
      CFG_Start   = stStart[c];
      PEB_BlkDone = stBlk[c];
      POOL_Rdy    = stRdy[c];
      @(negedge clk);
      obs = {CTRLPEB_FrtBlk, CTRLPEB_FnhFrm, PEB_Stall, POOLPEB_EnRd, POOL_Vld, POOL_Lst, SCH_Busy, SCH_Done};
      exp = {exFrt[c], exFnh[c], exStall[c], exEnRd[c], exVld[c], exLst[c], exBusy[c], exDone[c]};
      check($sformatf("%s c%0d frt,fnh,stall,enrd,vld,lst,busy,done", name, c), {24'd0, obs}, {24'd0, exp});
      if (exEnRd[c]) check($sformatf("%s c%0d addr", name, c), {28'd0, POOLPEB_AddrRd}, exAddr[c]);
    end
    @(posedge clk); #1;
    CFG_Start = 1'b0; PEB_BlkDone = 1'b0; POOL_Rdy = 1'b0;
  endtask

  task automatic resetMidReadout();
    bit hit;
    CFG_NumBlk = 8'd1; CFG_NumFrm = 8'd1; POOL_Rdy = 1'b1;
    @(posedge clk); #1; CFG_Start = 1'b1;
    @(posedge clk); #1; CFG_Start = 1'b0; PEB_BlkDone = 1'b1;
    @(posedge clk); #1; PEB_BlkDone = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      if (POOLPEB_EnRd && POOLPEB_AddrRd == 4'd7) hit = 1'b1;
    end
    check("rst reach addr7", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst enrd,vld,busy,fnh,done", {27'd0, POOLPEB_EnRd, POOL_Vld, SCH_Busy, CTRLPEB_FnhFrm, SCH_Done}, 32'd0);
    check("rst addr", {28'd0, POOLPEB_AddrRd}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("post-rst c%0d fnh,done,busy,enrd", k),
            {28'd0, CTRLPEB_FnhFrm, SCH_Done, SCH_Busy, POOLPEB_EnRd}, 32'd0);
    end
    POOL_Rdy = 1'b0;
  endtask

  initial begin
    int nb, nf;
    rst_n = 1'b0; CFG_Start = 1'b0; CFG_NumBlk = 8'd0; CFG_NumFrm = 8'd0;
    PEB_BlkDone = 1'b0; POOL_Rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {24'd0, CTRLPEB_FrtBlk, CTRLPEB_FnhFrm, PEB_Stall, POOLPEB_EnRd,
                            POOL_Vld, POOL_Lst, SCH_Busy, SCH_Done}, 32'd0);
    check("reset addr", {28'd0, POOLPEB_AddrRd}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    buildScenario(4, 1, 20, 0); runScenario("nb4nf1");
    buildScenario(2, 1, 5, 1);  runScenario("rdytoggle");
    buildScenario(1, 3, 4, 0);  runScenario("nb1nf3");
    buildScenario(0, 0, 3, 0);  runScenario("zerocfg");
    resetMidReadout();
    buildScenario(1, 1, 2, 0);  runScenario("afterrst");
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(0, 4);
      nf = $urandom_range(0, 3);
      buildScenario(nb, nf, 0, 2);
      runScenario($sformatf("rand%0d_nb%0d_nf%0d", r, nb, nf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
